// File: rtl/tcm_port_arb_if.sv
// One requester's TCM access channel: request/payload from the master,
// grant and read return from the arbiter.
interface tcm_port_arb_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/tcm_port_arb.sv
// Shares the single-port TCM between the CPU data port (p0) and the AXI bridge (p1).
// Fixed priority to p0 with a bounded-wait override for p1, plus a contention counter.
module tcm_port_arb #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tcm_port_arb_if.slave     p0,
  tcm_port_arb_if.slave     p1,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0]       wait_q, wait_d;
  logic [1:0]       rd_tag_q, rd_tag_d;  // {valid, port id}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0, gnt1, win_we;
  logic             rv0, rv1;

  always_comb begin
    gnt1 = ~rst_i & p1.req & (~p0.req | (wait_q == MaxWait));
    gnt0 = ~rst_i & p0.req & ~gnt1;

    ram_en_o    = gnt0 | gnt1;
    ram_we_o    = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    win_we      = 1'b0;
    if (gnt1) begin
      win_we      = p1.we;
      ram_addr_o  = p1.addr;
      ram_wdata_o = p1.wdata;
      ram_we_o    = p1.we ? p1.wstrb : 4'b0000;
    end else if (gnt0) begin
      win_we      = p0.we;
      ram_addr_o  = p0.addr;
      ram_wdata_o = p0.wdata;
      ram_we_o    = p0.we ? p0.wstrb : 4'b0000;
    end

    wait_d = 4'd0;
    if (p1.req && !gnt1) begin
      wait_d = (wait_q < MaxWait) ? wait_q + 4'd1 : MaxWait;
    end

    rd_tag_d = {ram_en_o & ~win_we, gnt1};

    cnt_d = cnt_q;
    if (p0.req && p1.req && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q   <= 4'd0;
      rd_tag_q <= 2'b00;
      cnt_q    <= '0;
    end else begin
      wait_q   <= wait_d;
      rd_tag_q <= rd_tag_d;
      cnt_q    <= cnt_d;
    end
  end

  // Masked by rst_i so a read tagged just before reset never returns.
  assign rv0 = rd_tag_q[1] & ~rd_tag_q[0] & ~rst_i;
  assign rv1 = rd_tag_q[1] &  rd_tag_q[0] & ~rst_i;

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign p0.rvalid = rv0;
  assign p1.rvalid = rv1;
  assign p0.rdata  = rv0 ? ram_rdata_i : 32'h0;
  assign p1.rdata  = rv1 ? ram_rdata_i : 32'h0;

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed bench for tcm_port_arb with a behavioural single-port RAM behind it.
module tb_tcm_port_arb;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  tcm_port_arb_if #(.ADDR_W(ADDR_W)) p0_if ();
  tcm_port_arb_if #(.ADDR_W(ADDR_W)) p1_if ();

  tcm_port_arb #(
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(4),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p0            (p0_if),
    .p1            (p1_if),
    .ram_en_o      (ram_en),
    .ram_we_o      (ram_we),
    .ram_addr_o    (ram_addr),
    .ram_wdata_o   (ram_wdata),
    .ram_rdata_i   (ram_rdata),
    .conflict_cnt_o(conflict_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    p0_if.req   = req;
    p0_if.we    = we;
    p0_if.addr  = addr;
    p0_if.wdata = wdata;
    p0_if.wstrb = wstrb;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    p1_if.req   = req;
    p1_if.we    = we;
    p1_if.addr  = addr;
    p1_if.wdata = wdata;
    p1_if.wstrb = wstrb;
  endtask

  logic [1:0] exp_g, prev_g;

  initial begin
    // Reset held with both ports requesting.
    rst = 1'b1;
    drive_p0(1'b1, 1'b0, 14'h0, 32'h0, 4'h0);
    drive_p1(1'b1, 1'b0, 14'h0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check("reset_quiet", 32'({p0_if.gnt, p1_if.gnt, ram_en, p0_if.rvalid, p1_if.rvalid}),
            32'h0);
    end
    cyc();
    rst = 1'b0;
    drive_p0(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    drive_p1(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("reset_cnt", 32'(conflict_cnt), 32'h0);
    check("reset_ram", 32'({ram_en, ram_we, ram_addr}), 32'h0);
    check("reset_rdata", p0_if.rdata | p1_if.rdata, 32'h0);

    // Preload 0x10 and 0x20 through p0.
    cyc();
    drive_p0(1'b1, 1'b1, 14'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("wr10_gnt", 32'({p0_if.gnt, p1_if.gnt}), 32'h2);
    check("wr10_we", 32'(ram_we), 32'hF);
    check("wr10_addr", 32'(ram_addr), 32'h10);
    cyc();
    drive_p0(1'b1, 1'b1, 14'h20, 32'hAAAAAAAA, 4'hF);
    @(negedge clk);
    check("wr20_gnt", 32'(p0_if.gnt), 32'h1);
    check("wr_no_rvalid", 32'(p0_if.rvalid), 32'h0);

    // Single read by p0.
    cyc();
    drive_p0(1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("rd10_gnt", 32'(p0_if.gnt), 32'h1);
    check("rd10_we", 32'(ram_we), 32'h0);
    cyc();
    drive_p0(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("rd10_rvalid", 32'({p0_if.rvalid, p1_if.rvalid}), 32'h2);
    check("rd10_rdata", p0_if.rdata, 32'hDEADBEEF);

    // Partial write by p1, then read by p0 next cycle.
    cyc();
    drive_p1(1'b1, 1'b1, 14'h20, 32'h12345678, 4'b0011);
    @(negedge clk);
    check("pw_gnt", 32'({p0_if.gnt, p1_if.gnt}), 32'h1);
    check("pw_we", 32'(ram_we), 32'h3);
    check("pw_wdata", ram_wdata, 32'h12345678);
    cyc();
    drive_p1(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    drive_p0(1'b1, 1'b0, 14'h20, 32'h0, 4'h0);
    @(negedge clk);
    check("pr_gnt", 32'(p0_if.gnt), 32'h1);
    // p1 read overlapping p0's read return.
    cyc();
    drive_p0(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    drive_p1(1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("pr_rvalid", 32'({p0_if.rvalid, p1_if.rvalid}), 32'h2);
    check("pr_rdata", p0_if.rdata, 32'hAAAA5678);
    check("ov_gnt", 32'(p1_if.gnt), 32'h1);
    check("ov_p1_rdata_idle", p1_if.rdata, 32'h0);
    cyc();
    drive_p1(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("ov_rvalid", 32'({p0_if.rvalid, p1_if.rvalid}), 32'h1);
    check("ov_rdata", p1_if.rdata, 32'hDEADBEEF);
    check("ov_p0_rdata_idle", p0_if.rdata, 32'h0);

    // Sustained contention: p0,p0,p0,p0,p1 repeating.
    prev_g = 2'b00;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (k == 0) begin
        drive_p0(1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
        drive_p1(1'b1, 1'b0, 14'h20, 32'h0, 4'h0);
      end
      @(negedge clk);
      exp_g = (k % 5 == 4) ? 2'b01 : 2'b10;
      check($sformatf("cont_gnt[%0d]", k), 32'({p0_if.gnt, p1_if.gnt}), 32'(exp_g));
      check($sformatf("cont_rv[%0d]", k), 32'({p0_if.rvalid, p1_if.rvalid}), 32'(prev_g));
      prev_g = exp_g;
    end
    cyc();
    drive_p0(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    drive_p1(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("cont_cnt", 32'(conflict_cnt), 32'd20);
    check("cont_last_rdata", p1_if.rdata, 32'hAAAA5678);

    // Reset lands on the cycle after a p1 read grant.
    cyc();
    drive_p1(1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("rr_gnt", 32'(p1_if.gnt), 32'h1);
    cyc();
    rst = 1'b1;
    drive_p1(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("rr_rvalid_in_rst", 32'({p0_if.rvalid, p1_if.rvalid}), 32'h0);
    check("rr_rdata_in_rst", p1_if.rdata, 32'h0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rr_rvalid_after", 32'({p0_if.rvalid, p1_if.rvalid}), 32'h0);
    check("rr_rdata_after", p1_if.rdata, 32'h0);
    check("rr_cnt_cleared", 32'(conflict_cnt), 32'h0);

    // Counter saturation at 8 bits.
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (k == 0) begin
        drive_p0(1'b1, 1'b0, 14'h10, 32'h0, 4'h0);
        drive_p1(1'b1, 1'b0, 14'h20, 32'h0, 4'h0);
      end
      @(negedge clk);
      if (k == 200) check("sat_mid", 32'(conflict_cnt), 32'd200);
      if (k == 255) check("sat_reach", 32'(conflict_cnt), 32'hFF);
    end
    cyc();
    drive_p0(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    drive_p1(1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("sat_hold", 32'(conflict_cnt), 32'hFF);
    check("idle_no_en", 32'({ram_en, ram_we}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
